wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin writeback arbiter: shares one writeback port among NUM_UNITS execution units, each presenting done/id/rd.
- Grants at most one unit per cycle and captures the winner into a registered output packet.
- Downstream back-pressure is supported through wb_ready.
- Sits between a writeback group's unit interfaces and the register-file/commit writeback port.

Parameters:
- NUM_UNITS, 4, number of requesting units (>=1, need not be a power of 2)
- XLEN, 32, result data width
- ID_W, 3, instruction ID width
- SEL_W, (NUM_UNITS==1 ? 1 : $clog2(NUM_UNITS)), width of unit index (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- unit_done  in  NUM_UNITS  unit k has a result pending; held until acked
- unit_id  in  NUM_UNITS*ID_W  unit k ID at [k*ID_W +: ID_W]
- unit_rd  in  NUM_UNITS*XLEN  unit k result at [k*XLEN +: XLEN]
- unit_ack  out  NUM_UNITS  one-hot grant; the unit retires its result this cycle
- wb_ready  in  1  downstream accepts wb packet this cycle
- wb_valid  out  1  registered packet valid
- wb_id  out  ID_W  registered packet ID
- wb_data  out  XLEN  registered packet data
- wb_unit  out  SEL_W  index of the unit that produced the packet

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: wb_valid=0, wb_id=0, wb_data=0, wb_unit=0, RR pointer ptr=0. unit_ack is forced to 0 while rst=1, even if unit_done is asserted.
- load_en = !wb_valid || wb_ready.
- Grant (combinational):
  - Search unit_done starting at index ptr, ascending, wrapping NUM_UNITS-1 -> 0.
  - The first set bit is the winner g.
  - unit_ack[g]=1 only if load_en && |unit_done && !rst; otherwise unit_ack=0.
- Capture on a grant: next cycle wb_valid=1, wb_id=unit_id[g], wb_data=unit_rd[g], wb_unit=g.
  - ptr <= (g==NUM_UNITS-1) ? 0 : g+1.
  - Wrap uses an explicit compare, so non-power-of-2 NUM_UNITS works.
- load_en with no done: wb_valid<=0; id/data/unit hold their previous values; ptr unchanged.
- Stall (wb_valid && !wb_ready): all output registers and ptr hold; no acks.
- Latency: 1 cycle from a granted done to wb_valid.
- Throughput: one packet per cycle when wb_ready=1 and requests are continuous. A packet consumed and a new grant in the same cycle is legal (back-to-back).
- Unit contract: done, id and rd are stable until acked. The unit deasserts done, or presents its next result, in the cycle after ack.
- NUM_UNITS==1: ptr is a constant 0; grant = unit_done[0] && load_en.
- Reset mid-stall: the pending packet is discarded (wb_valid=0) and no ack is issued during rst.
- Fairness: any requesting unit is granted within NUM_UNITS grants.

Optional Feature:
- Macro: WB_ARB_PRIO0_EN.
- Defined:
  - Unit 0 (single-cycle ALU) has strict priority. If unit_done[0] && load_en, unit 0 is granted regardless of ptr.
  - Remaining units round-robin among 1..NUM_UNITS-1; ptr wraps NUM_UNITS-1 -> 1, resets to 1, and advances only on non-zero grants.
  - Units 1..N-1 may starve while unit 0 requests continuously.
  - NUM_UNITS==1 behaves as base.
- Not defined: unit 0 takes part in plain round-robin.

Test Plan:
- Reset: rst=1 for 2 cycles with unit_done=4'b1111 -> unit_ack=0, wb_valid=0. Cycle after release -> ack unit 0; next cycle wb_valid=1, wb_unit=0, wb_data=unit_rd[0].
- Continuous requests: all done, distinct rd=0x10..0x13, wb_ready=1 -> acks 0,1,2,3,0 on consecutive cycles; wb_data 0x10,0x11,0x12,0x13,0x10 one cycle later, no bubbles.
- Stall: wb_valid=1, wb_ready=0 for 3 cycles with unit_done[2]=1 -> no acks, wb_* stable. Raise wb_ready -> ack[2] same cycle; next cycle wb_unit=2 with wb_valid still 1.
- Wrap: after a grant to unit 2 (ptr=3), done on units 1 and 3 -> grant 3, then grant 1; ptr ends at 2.
- Idle/drain: no done, wb_ready=1 -> wb_valid drops to 0 next cycle; ptr unchanged; wb_id/wb_data hold.
- Priority: unit_done[0] and unit_done[2] held at 1 -> with WB_ARB_PRIO0_EN, ack[0] every cycle and unit 2 never acked; without it, acks alternate 0,2,0,2.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Writeback arbiter bus: unit result handshakes plus the registered writeback packet.
// master = the arbiter, slave = the units/downstream side driving requests and ready.
interface wb_rr_arbiter_if #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32,
    parameter int ID_W      = 3,
    parameter int SEL_W     = (NUM_UNITS == 1) ? 1 : $clog2(NUM_UNITS)
) ();
    logic [NUM_UNITS-1:0]      unit_done;
    logic [NUM_UNITS*ID_W-1:0] unit_id;
    logic [NUM_UNITS*XLEN-1:0] unit_rd;
    logic [NUM_UNITS-1:0]      unit_ack;
    logic                      wb_ready;
    logic                      wb_valid;
    logic [ID_W-1:0]           wb_id;
    logic [XLEN-1:0]           wb_data;
    logic [SEL_W-1:0]          wb_unit;

    modport master (
        input  unit_done, unit_id, unit_rd, wb_ready,
        output unit_ack, wb_valid, wb_id, wb_data, wb_unit
    );

    modport slave (
        output unit_done, unit_id, unit_rd, wb_ready,
        input  unit_ack, wb_valid, wb_id, wb_data, wb_unit
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin writeback arbiter: grants one unit per cycle into a registered wb packet.
// Optional WB_ARB_PRIO0_EN: unit 0 has strict priority, units 1..N-1 share the round-robin.
module wb_rr_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32,
    parameter int ID_W      = 3,
    parameter int SEL_W     = (NUM_UNITS == 1) ? 1 : $clog2(NUM_UNITS)
) (
    input  logic            clk,
    input  logic            rst,
    wb_rr_arbiter_if.master bus
);
`ifdef WB_ARB_PRIO0_EN
    localparam bit PRIO0_EN = (NUM_UNITS > 1);
`else
    localparam bit PRIO0_EN = 1'b0;
`endif
    // Lowest index that takes part in the rotating search.
    localparam int               PTR_LO  = PRIO0_EN ? 1 : 0;
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(PTR_LO);

    logic [SEL_W-1:0]     ptr_r;
    logic                 wb_valid_r;
    logic [ID_W-1:0]      wb_id_r;
    logic [XLEN-1:0]      wb_data_r;
    logic [SEL_W-1:0]     wb_unit_r;

    logic                 load_en_s;
    logic                 found_hi_s;
    logic                 found_lo_s;
    logic [SEL_W-1:0]     win_hi_s;
    logic [SEL_W-1:0]     win_lo_s;
    logic [SEL_W-1:0]     win_s;
    logic                 any_s;
    logic                 grant_s;
    logic [NUM_UNITS-1:0] ack_s;

    assign load_en_s = !wb_valid_r || bus.wb_ready;

    // Two-pass rotating search: first requester at/above ptr, else first one below it.
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        win_hi_s   = '0;
        win_lo_s   = '0;
        for (int k = PTR_LO; k < NUM_UNITS; k++) begin
            win_hi_s   = (!found_hi_s && bus.unit_done[k] && (k >= int'(ptr_r))) ? k[SEL_W-1:0] : win_hi_s;
            found_hi_s = found_hi_s || (bus.unit_done[k] && (k >= int'(ptr_r)));
            win_lo_s   = (!found_lo_s && bus.unit_done[k] && (k < int'(ptr_r))) ? k[SEL_W-1:0] : win_lo_s;
            found_lo_s = found_lo_s || (bus.unit_done[k] && (k < int'(ptr_r)));
        end
    end

    // Winner selection, grant qualification and one-hot ack.
    always_comb begin
        win_s = '0;
        any_s = 1'b0;
        if (PRIO0_EN && bus.unit_done[0]) begin
            win_s = '0;
            any_s = 1'b1;
        end else if (found_hi_s) begin
            win_s = win_hi_s;
            any_s = 1'b1;
        end else begin
            win_s = win_lo_s;
            any_s = found_lo_s;
        end
        grant_s = load_en_s && any_s && !rst;
        ack_s   = '0;
        if (grant_s) begin
            ack_s[win_s] = 1'b1;
        end else begin
            ack_s = '0;
        end
    end

    // Packet capture and pointer advance; a prioritised unit-0 grant leaves ptr alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_r <= 1'b0;
            wb_id_r    <= '0;
            wb_data_r  <= '0;
            wb_unit_r  <= '0;
            ptr_r      <= PTR_RST;
        end else if (grant_s) begin
            wb_valid_r <= 1'b1;
            wb_id_r    <= bus.unit_id[int'(win_s)*ID_W +: ID_W];
            wb_data_r  <= bus.unit_rd[int'(win_s)*XLEN +: XLEN];
            wb_unit_r  <= win_s;
            if (int'(win_s) >= PTR_LO) begin
                ptr_r <= (int'(win_s) == NUM_UNITS - 1) ? PTR_RST : win_s + SEL_W'(1);
            end
        end else if (load_en_s) begin
            wb_valid_r <= 1'b0;
        end
    end

    assign bus.unit_ack = ack_s;
    assign bus.wb_valid = wb_valid_r;
    assign bus.wb_id    = wb_id_r;
    assign bus.wb_data  = wb_data_r;
    assign bus.wb_unit  = wb_unit_r;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed literal checks plus a randomized run compared each cycle
// against a queue-free arithmetic model of the round-robin (and WB_ARB_PRIO0_EN) rules.
module tb_wb_rr_arbiter;
    localparam int N     = 4;
    localparam int XLEN  = 32;
    localparam int ID_W  = 3;
    localparam int SEL_W = 2;
`ifdef WB_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam int LO   = (PRIO && N > 1) ? 1 : 0;
    localparam int SPAN = N - LO;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [N-1:0]    done_v = '0;
    logic [ID_W-1:0] id_v [N];
    logic [XLEN-1:0] rd_v [N];

    wb_rr_arbiter_if #(.NUM_UNITS(N), .XLEN(XLEN), .ID_W(ID_W), .SEL_W(SEL_W)) bus ();
    wb_rr_arbiter #(.NUM_UNITS(N), .XLEN(XLEN), .ID_W(ID_W), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.unit_done = done_v;
        bus.unit_id   = '0;
        bus.unit_rd   = '0;
        for (int k = 0; k < N; k++) begin
            bus.unit_id[k*ID_W +: ID_W] = id_v[k];
            bus.unit_rd[k*XLEN +: XLEN] = rd_v[k];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rule: strict unit 0 (if enabled), else first requester from ptr cyclically.
    function automatic int pick(input logic [N-1:0] d, input int p);
        int k;
        if (PRIO && N > 1 && d[0]) return 0;
        for (int o = 0; o < SPAN; o++) begin
            k = LO + ((p - LO + o) % SPAN);
            if (d[k]) return k;
        end
        return -1;
    endfunction

    int              m_ptr   = LO;
    logic            m_valid = 1'b0;
    logic [ID_W-1:0] m_id    = '0;
    logic [XLEN-1:0] m_data  = '0;
    int              m_unit  = 0;
    logic [N-1:0]    last_ack = '0;
    int              cmp_g;
    logic [N-1:0]    cmp_ack;

    // Per-cycle comparison against the model, then the model advances one clock.
    always @(negedge clk) begin
        cmp_ack = '0;
        cmp_g   = -1;
        if (!rst && (!m_valid || bus.wb_ready)) cmp_g = pick(bus.unit_done, m_ptr);
        if (cmp_g >= 0) cmp_ack[cmp_g] = 1'b1;
        chk("model_ack",   64'(bus.unit_ack), 64'(cmp_ack));
        chk("model_valid", 64'(bus.wb_valid), 64'(m_valid));
        chk("model_id",    64'(bus.wb_id),    64'(m_id));
        chk("model_data",  64'(bus.wb_data),  64'(m_data));
        chk("model_unit",  64'(bus.wb_unit),  64'(m_unit));
        last_ack = cmp_ack;
        if (rst) begin
            m_valid = 1'b0; m_id = '0; m_data = '0; m_unit = 0; m_ptr = LO;
        end else if (cmp_g >= 0) begin
            m_valid = 1'b1;
            m_id    = id_v[cmp_g];
            m_data  = rd_v[cmp_g];
            m_unit  = cmp_g;
            if (cmp_g >= LO) m_ptr = LO + ((cmp_g - LO + 1) % SPAN);
        end else if (!m_valid || bus.wb_ready) begin
            m_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            id_v[k] = ID_W'(k + 1);
            rd_v[k] = XLEN'(32'h10 + k);
        end
        done_v       = '1;
        bus.wb_ready = 1'b1;

        // Reset held with all units requesting: no acks, nothing valid.
        @(negedge clk);
        chk("rst_ack_0",   64'(bus.unit_ack), 64'd0);
        chk("rst_valid_0", 64'(bus.wb_valid), 64'd0);
        step();
        @(negedge clk);
        chk("rst_ack_1",   64'(bus.unit_ack), 64'd0);
        chk("rst_valid_1", 64'(bus.wb_valid), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ack", 64'(bus.unit_ack), 64'd1);
        step();
        @(negedge clk);
        chk("rel_valid", 64'(bus.wb_valid), 64'd1);
        chk("rel_unit",  64'(bus.wb_unit),  64'd0);
        chk("rel_data",  64'(bus.wb_data),  64'h10);
`ifndef WB_ARB_PRIO0_EN
        chk("cont_ack_1", 64'(bus.unit_ack), 64'd2);
        step();
        for (int i = 2; i < 6; i++) begin
            @(negedge clk);
            chk("cont_ack",  64'(bus.unit_ack), 64'd1 << (i % 4));
            chk("cont_data", 64'(bus.wb_data),  64'h10 + 64'((i - 1) % 4));
            chk("cont_valid", 64'(bus.wb_valid), 64'd1);
            step();
        end
        // Stall with unit 2 waiting; packet from unit 1 must hold.
        done_v = 4'b0100;
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ack",  64'(bus.unit_ack), 64'd0);
            chk("stall_unit", 64'(bus.wb_unit),  64'd1);
            chk("stall_data", 64'(bus.wb_data),  64'h11);
            step();
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk("unstall_ack", 64'(bus.unit_ack), 64'd4);
        step();
        done_v = 4'b1010;
        @(negedge clk);
        chk("unstall_unit",  64'(bus.wb_unit),  64'd2);
        chk("unstall_valid", 64'(bus.wb_valid), 64'd1);
        chk("wrap_ack_3",    64'(bus.unit_ack), 64'd8);
        step();
        done_v = 4'b0010;
        @(negedge clk);
        chk("wrap_ack_1",  64'(bus.unit_ack), 64'd2);
        chk("wrap_unit_3", 64'(bus.wb_unit),  64'd3);
        step();
        done_v = 4'b0000;
        @(negedge clk);
        chk("wrap_unit_1", 64'(bus.wb_unit), 64'd1);
        step();
        @(negedge clk);
        chk("idle_valid", 64'(bus.wb_valid), 64'd0);
        chk("idle_data",  64'(bus.wb_data),  64'h11);
        chk("idle_id",    64'(bus.wb_id),    64'd2);
        step();
        done_v = 4'b1111;
        @(negedge clk);
        chk("idle_ptr_ack", 64'(bus.unit_ack), 64'd4);
        step();
`else
        step();
`endif
        // Units 0 and 2 requesting continuously.
        done_v = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("prio_ack", 64'(bus.unit_ack), (PRIO || (i % 2 == 0)) ? 64'd1 : 64'd4);
            step();
        end
        // Reset arriving during a stall discards the pending packet.
        bus.wb_ready = 1'b0;
        @(negedge clk);
        chk("mstall_ack",   64'(bus.unit_ack), 64'd0);
        chk("mstall_valid", 64'(bus.wb_valid), 64'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_ack", 64'(bus.unit_ack), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 64'(bus.wb_valid), 64'd0);
        chk("mrst_data",  64'(bus.wb_data),  64'd0);
        chk("mrst_ack2",  64'(bus.unit_ack), 64'd1);
        step();

        // Randomized traffic honouring the unit contract (hold until acked).
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            bus.wb_ready = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < N; k++) begin
                if (last_ack[k] || !done_v[k]) begin
                    done_v[k] = ($urandom_range(0, 9) < (3 + 3 * ((c / 500) % 3)));
                    id_v[k]   = ID_W'($urandom);
                    rd_v[k]   = XLEN'($urandom);
                end
            end
            step();
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
